// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: operation codes and FSM states.
// Latency: none (type definitions only).
// Backpressure: none.
package muldiv_pkg;

  // Operation requested by the ALU-control decode
  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIVU = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the engine: shift-add multiply or restoring divide.
// Latency: combinational; the sequencer registers the results once per cycle.
// Backpressure: none; the sequencer only applies the outputs while in RUN.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int N = 4
) (
  input  op_t            op_i,
  input  logic [2*N-1:0] acc_i,      // MULT: {partial product, multiplier}; DIVU: {unused, dividend/quotient}
  input  logic [N:0]     rem_i,      // DIVU partial remainder
  input  logic [N-1:0]   operand_i,  // MULT multiplicand / DIVU divisor
  output logic [2*N-1:0] acc_o,
  output logic [N:0]     rem_o,
  output logic           qbit_o
);

  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] trial;

  // Compute both datapaths; op_i selects which one updates the accumulator
  always_comb begin
    // Multiply: add multiplicand to the upper half when the multiplier LSB is set,
    // then shift right; the carry lands in the accumulator MSB.
    sum     = {1'b0, acc_i[2*N-1:N]} + (acc_i[0] ? {1'b0, operand_i} : {(N+1){1'b0}});
    // Divide: bring the next dividend bit into the remainder and trial-subtract.
    shifted = (rem_i << 1) | {{N{1'b0}}, acc_i[N-1]};
    trial   = shifted - {1'b0, operand_i};
    qbit_o  = (shifted >= {1'b0, operand_i});
    rem_o   = qbit_o ? trial : shifted;
    acc_o   = acc_i;
    if (op_i == OP_MULT) begin
      acc_o = {sum, acc_i[N-1:1]};
    end else if (op_i == OP_DIVU) begin
      acc_o = {acc_i[2*N-1:N], acc_i[N-2:0], qbit_o};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide controller owning the architectural HI/LO registers.
// Latency: MULT/DIVU done N cycles after accept, MTHI/MTLO 0 (done in the cycle after accept).
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
// Optional feature macro MULDIV_DIV0_FAST_EN: DIVU by zero completes at the accept edge.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  op_t          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t          state_q;
  op_t             op_q;
  logic [2*N-1:0]  acc_q;
  logic [N:0]      rem_q;
  logic [N-1:0]    opnd_q;
  logic [CW-1:0]   count_q;
  logic [N-1:0]    hi_q;
  logic [N-1:0]    lo_q;
  logic            busy_q;
  logic            done_q;
  logic            div0_q;

  logic [2*N-1:0]  acc_d;
  logic [N:0]      rem_d;
  logic            qbit_d;

  muldiv_step #(.N(N)) u_step (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .rem_i     (rem_q),
    .operand_i (opnd_q),
    .acc_o     (acc_d),
    .rem_o     (rem_d),
    .qbit_o    (qbit_d)
  );

  // FSM, iteration counter, working registers and HI/LO, all with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      acc_q   <= '0;
      rem_q   <= '0;
      opnd_q  <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            count_q <= '0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b1;
            case (op)
              OP_MULT: begin
                // Multiplier sits in the low half and is consumed LSB first
                acc_q   <= {{N{1'b0}}, b};
                opnd_q  <= a;
                state_q <= S_RUN;
              end
              OP_DIVU: begin
                // Dividend sits in the low half and is consumed MSB first
                acc_q  <= {{N{1'b0}}, a};
                rem_q  <= '0;
                opnd_q <= b;
`ifdef MULDIV_DIV0_FAST_EN
                if (b == '0) begin
                  hi_q    <= a;
                  lo_q    <= '1;
                  div0_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  state_q <= S_RUN;
                end
`else
                state_q <= S_RUN;
`endif
              end
              OP_MTHI: begin
                hi_q    <= a;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              OP_MTLO: begin
                lo_q    <= a;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            endcase
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (count_q == LAST_CNT) begin
            // Final iteration: commit HI and LO together from the step outputs
            count_q <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (op_q == OP_MULT) begin
              {hi_q, lo_q} <= acc_d;
            end else begin
              hi_q   <= rem_d[N-1:0];
              lo_q   <= {acc_q[N-2:0], qbit_d};
              div0_q <= (opnd_q == '0);
            end
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = div0_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios plus randomized traffic against a
// latency/result model built from plain arithmetic.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int N = 4;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 0;
`else
  localparam int DIV0_LAT = N;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  op_t          op;
  logic [N-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [N-1:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  muldiv_sequencer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks edges since accept and the operation's latency; results come from * / %.
  logic [N-1:0] m_hi = '0, m_lo = '0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_d0 = 1'b0;
  int           m_t = 0, m_lat = 0;
  op_t          r_op = OP_MULT;
  logic [N-1:0] r_hi = '0, r_lo = '0;
  logic         r_d0 = 1'b0;

  task automatic m_apply();
    if (r_op == OP_MULT || r_op == OP_DIVU) begin
      m_hi = r_hi; m_lo = r_lo; m_d0 = r_d0;
    end else if (r_op == OP_MTHI) begin
      m_hi = r_hi;
    end else begin
      m_lo = r_lo;
    end
    m_done = 1'b1;
  endtask

  always @(posedge clk or posedge reset) begin
    logic [2*N-1:0] prod;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_d0 = 0; m_t = 0; m_lat = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_t++;
        if (m_t == m_lat) m_apply();
        if (m_t == m_lat + 1) m_busy = 1'b0;
      end else if (start) begin
        m_busy = 1'b1; m_t = 0; m_d0 = 1'b0; r_op = op; r_d0 = 1'b0;
        case (op)
          OP_MULT: begin
            prod = (2*N)'(a) * (2*N)'(b);
            r_hi = prod[2*N-1:N]; r_lo = prod[N-1:0]; m_lat = N;
          end
          OP_DIVU: begin
            if (b == 0) begin
              r_hi = a; r_lo = '1; r_d0 = 1'b1; m_lat = DIV0_LAT;
            end else begin
              r_hi = a % b; r_lo = a / b; m_lat = N;
            end
          end
          OP_MTHI: begin r_hi = a; m_lat = 0; end
          default: begin r_lo = a; m_lat = 0; end
        endcase
        if (m_lat == 0) m_apply();
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", 32'(hi), 32'(m_hi));
      chk("lo", 32'(lo), 32'(m_lo));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_d0));
    end
  end

  // Issue one op, optionally poke start during RUN, and check literal results and latency
  task automatic run_op(input string nm, input op_t o, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [N-1:0] ehi, input logic [N-1:0] elo, input logic ed0,
                        input int elat, input bit poke);
    int k;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      if (poke && k == 1) begin start = 1'b1; op = OP_MULT; a = 4'h7; b = 4'h2; end
      if (poke && k == 2) start = 1'b0;
    end
    start = 1'b0;
    if (k >= 20) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: done not seen within 20 cycles", nm);
    end else begin
      chk({nm, "_latency"}, 32'(k), 32'(elat));
      chk({nm, "_hi"}, 32'(hi), 32'(ehi));
      chk({nm, "_lo"}, 32'(lo), 32'(elo));
      chk({nm, "_d0"}, 32'(div_by_zero), 32'(ed0));
    end
  endtask

  initial begin
    int busy_cnt;
    reset = 1'b1; start = 1'b0; op = OP_MULT; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    // 1. idle after reset
    repeat (3) @(negedge clk);
    chk("rst_hi", 32'(hi), 0);
    chk("rst_lo", 32'(lo), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_d0", 32'(div_by_zero), 0);

    // 2. MULT F*F, plus busy duration
    run_op("mult_ff", OP_MULT, 4'hF, 4'hF, 4'hE, 4'h1, 1'b0, 4, 1'b0);
    busy_cnt = 5;  // cycles after edge 0 .. edge N inclusive
    @(negedge clk);
    chk("mult_busy_drop", 32'(busy), 0);
    // measure busy length directly
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 4'h2; b = 4'h3;
    @(negedge clk);
    start = 1'b0;
    begin
      int c = 0;
      while (busy && c < 20) begin c++; @(negedge clk); end
      chk("busy_cycles", 32'(c), 32'(busy_cnt));
    end

    // 3. DIVU D/3 with an ignored start during RUN
    run_op("divu_d3", OP_DIVU, 4'hD, 4'h3, 4'h1, 4'h4, 1'b0, 4, 1'b1);
    // 4. DIVU by zero
    run_op("divu_by0", OP_DIVU, 4'h9, 4'h0, 4'h9, 4'hF, 1'b1, DIV0_LAT, 1'b0);
    // 5. MTHI then MTLO (div_by_zero clears on accept)
    run_op("mthi", OP_MTHI, 4'h5, 4'h0, 4'h5, 4'hF, 1'b0, 0, 1'b0);
    run_op("mtlo", OP_MTLO, 4'hA, 4'h0, 4'h5, 4'hA, 1'b0, 0, 1'b0);

    // 6. MULT 3*3 aborted by reset at edge 2
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 4'h3; b = 4'h3;
    @(negedge clk);  // after edge 0
    start = 1'b0;
    @(negedge clk);  // after edge 1
    @(posedge clk);  // edge 2
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_hi", 32'(hi), 0);
    chk("abort_lo", 32'(lo), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    run_op("after_abort", OP_MULT, 4'h3, 4'h5, 4'h0, 4'hF, 1'b0, 4, 1'b0);

    // Randomized traffic with stray start pulses; the model checks every cycle
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b1;
      op = op_t'($urandom_range(0, 3));
      a = N'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      for (int c = 0; c < $urandom_range(1, N + 3); c++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        op = op_t'($urandom_range(0, 3));
        a = N'($urandom);
        b = N'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    start = 1'b0;
    repeat (N + 3) @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
